// File: rtl/wb_pipe_skid_if.sv
// Handshake bundle for the MEM/WB skid stage: upstream beat, downstream head,
// flush, registered sideband and occupancy.
interface wb_pipe_skid_if #(
    parameter int DW  = 32,
    parameter int SBW = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [SBW-1:0] in_side;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [SBW-1:0] out_side;
    logic [1:0]     occ;

    // Stage side.
    modport slave (
        input  in_valid, in_data, in_side, flush, out_ready,
        output in_ready, out_valid, out_data, out_side, occ
    );

    // Environment side: feeds beats upstream and consumes the head.
    modport master (
        output in_valid, in_data, in_side, flush, out_ready,
        input  in_ready, out_valid, out_data, out_side, occ
    );
endinterface

// File: rtl/wb_pipe_skid.sv
// Two-entry valid/ready skid stage between pipeline stages (e.g. MEM -> WB),
// with synchronous flush and a free-running, reset-only sideband register.
module wb_pipe_skid #(
    parameter int DW           = 32,
    parameter int SBW          = 32,
    parameter bit CLR_ON_FLUSH = 1'b1
) (
    input  logic           clk,
    input  logic           cpurst,
    wb_pipe_skid_if.slave  bus
);
    logic           r_main_v;
    logic           r_skid_v;
    logic [DW-1:0]  r_main_d;
    logic [DW-1:0]  r_skid_d;
    logic [SBW-1:0] r_side;

    logic w_in_ready;
    logic w_acc;
    logic w_deq;

    // A beat moves when valid & ready are both high at a rising edge. in_ready
    // depends only on stored state and flush, never on out_ready, so the
    // backpressure chain is cut here. A head seen during flush is not delivered.
    assign w_in_ready = ~r_skid_v & ~bus.flush;
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_deq      = r_main_v & bus.out_ready;

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
            r_side   <= '0;
        end else begin
            r_side <= bus.in_side;
            if (bus.flush) begin
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
                if (CLR_ON_FLUSH) begin
                    r_main_d <= '0;
                    r_skid_d <= '0;
                end
            end else if (!r_main_v) begin
                if (w_acc) begin
                    r_main_v <= 1'b1;
                    r_main_d <= bus.in_data;
                end
            end else if (w_deq) begin
                if (r_skid_v) begin
                    r_main_d <= r_skid_d;
                    r_skid_v <= 1'b0;
                end else if (w_acc) begin
                    r_main_d <= bus.in_data;
                end else begin
                    r_main_v <= 1'b0;
                end
            end else if (w_acc) begin
                r_skid_v <= 1'b1;
                r_skid_d <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_main_v;
    assign bus.out_data  = r_main_d;
    assign bus.out_side  = r_side;
    assign bus.occ       = {1'b0, r_main_v} + {1'b0, r_skid_v};

    // The skid entry only fills behind a held head.
    a_skid_implies_main: assert property (
        @(posedge clk) disable iff (cpurst) r_skid_v |-> r_main_v
    );
endmodule

// File: doc/wb_pipe_skid.md
Name: wb_pipe_skid

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- It replaces the single-stage "zero on stall" register with a two-entry valid/ready skid stage. It carries an arbitrary-width payload and adds a synchronous flush.
- It also keeps a free-running sideband register (PC-style) that is reset-only.
- It sits between any two pipeline stages, for example between memory access and write-back. Backpressure from write-back does not lose or duplicate a beat.

Parameters:
DW, 32, payload width in bits (packed rd/csr/exception fields), min 1
SBW, 32, free-running sideband width in bits (PC), min 1
CLR_ON_FLUSH, 1, 1 = flush zeroes stored payload; 0 = flush clears valid bits only

Ports:
clk  input  1  clock, rising edge
cpurst  input  1  asynchronous active-high reset
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
in_data  input  DW  upstream payload
in_side  input  SBW  sideband, sampled every cycle
flush  input  1  synchronous pipeline flush (exception/mret/interrupt)
out_valid  output  1  head beat valid
out_ready  input  1  downstream accepts head beat
out_data  output  DW  head payload
out_side  output  SBW  registered sideband
occ  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset (asynchronous, cpurst=1):
  - main_v=0, skid_v=0, main_d=0, skid_d=0, out_side=0.
  - Hence out_valid=0, out_data=0, occ=0, in_ready=1 once flush=0.
  - Deassertion takes effect at the next clk edge.
- Storage:
  - main register (head) drives out_data/out_valid directly from flops.
  - skid register holds one overflow beat.
- in_ready = ~skid_v & ~flush. The only combinational path is from flush; there is no path from out_ready.
- acc = in_valid & in_ready. deq = out_valid & out_ready.
- Transitions when flush=0, per edge:
  - main empty, acc: main <= in.
  - main full, deq, skid empty, acc: main <= in (pass-through, 1 beat/cycle).
  - main full, deq, skid empty, no acc: main_v <= 0.
  - main full, no deq, acc (skid necessarily empty): skid <= in.
  - main full, deq, skid full: main <= skid, skid_v <= 0. in_ready was 0, so no acc.
  - main full, no deq, skid full: hold everything.
- Ordering: strictly FIFO. No beat is dropped or duplicated unless flushed.
- Latency: a beat accepted at edge N is visible on out_* after edge N when the stage was empty.
- Flush (highest priority after reset):
  - At the edge: main_v <= 0 and skid_v <= 0. Both data registers are zeroed only when CLR_ON_FLUSH=1; otherwise data holds.
  - in_ready=0 during flush, so no beat is accepted.
  - A head with out_ready=1 during flush is NOT considered delivered. Downstream must qualify with flush.
- Sideband: out_side <= in_side every edge. It ignores handshake, flush and occupancy; only cpurst clears it.
- occ = main_v + skid_v. Invariant: skid_v implies main_v. Reaching skid_v=1 with main_v=0 is a design error; add an assertion.
- Payload while out_valid=0:
  - When CLR_ON_FLUSH=1, out_data is 0 after reset or flush.
  - After a normal drain, out_data holds the last value. Consumers must qualify with out_valid.

Test Plan:
- Reset mid-traffic: main and skid holding 0xA5A5A5A5/0x5A5A5A5A, assert cpurst asynchronously between edges -> out_valid=0, out_data=0, out_side=0, occ=0 immediately. After release, in_ready=1.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive edges -> out_data 1,2,3,4 one cycle later, one per cycle; occ stays 1; in_ready stays 1.
- Backpressure: out_ready=0, push 0x11 then 0x22 -> occ=2, in_ready=0, and a third beat 0x33 is not accepted. Raise out_ready -> 0x11 then 0x22 are delivered; in_ready returns 1 after the first deq. Hold 0x33 on in_valid until in_ready=1; it is accepted and delivered after 0x22.
- Flush full: occ=2, flush=1 for one cycle with in_valid=1, in_data=0x77 -> in_ready=0 that cycle. Next cycle occ=0, out_valid=0, out_data=0 (CLR_ON_FLUSH=1). 0x77 never appears.
- Flush, CLR_ON_FLUSH=0: same stimulus -> out_valid=0, and out_data retains the previous head value.
- Sideband: in_side increments 0x100, 0x104, 0x108 across a flush and a full stall -> out_side follows one cycle later on every edge, unaffected by flush or stall.
